// File: rtl/alarm_if.sv
`default_nettype none
// ============================================================================
// Module  : alarm_if
// Brief   : Zone/temperature inputs and indicator outputs of alarm_controller.
// Rev     : 1.0
// ============================================================================
interface alarm_if;
    logic [3:0] state;
    logic       temp_delta_sign;
    logic [5:0] temp_delta;
    logic [3:0] temp_delta_frac;
    logic       ack;
    logic       led_normal;
    logic       led_border;
    logic       led_attn;
    logic       led_emerg;
    logic       buzzer;
    logic       alarm_latched;
    logic [9:0] peak_rise;

    modport master (
        output state, temp_delta_sign, temp_delta, temp_delta_frac, ack,
        input  led_normal, led_border, led_attn, led_emerg,
        input  buzzer, alarm_latched, peak_rise
    );

    modport slave (
        input  state, temp_delta_sign, temp_delta, temp_delta_frac, ack,
        output led_normal, led_border, led_attn, led_emerg,
        output buzzer, alarm_latched, peak_rise
    );
endinterface
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module  : alarm_controller
// Brief   : Zone indicator FSM with blinking LEDs, mutable buzzer, peak rise.
// Rev     : 1.0
// ============================================================================
module alarm_controller #(
    parameter int BLINK_DIV     = 25000000,
    parameter int SILENCE_TICKS = 8
) (
    input  logic    clk,
    input  logic    rst,
    alarm_if.slave  bus
);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SIL_W = (SILENCE_TICKS > 0) ? $clog2(SILENCE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [SIL_W-1:0] SIL_TOP = SIL_W'(SILENCE_TICKS);

    typedef enum logic [2:0] {
        RUN_NORMAL   = 3'd0,
        RUN_BORDER   = 3'd1,
        RUN_ATTN     = 3'd2,
        ALARM_SOUND  = 3'd3,
        ALARM_SILENT = 3'd4
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_wrap;
    logic             w_phase_next;
    logic [SIL_W-1:0] r_sil;
    logic [SIL_W-1:0] w_sil_next;
    logic [9:0]       w_rise;

    assign w_wrap       = (r_cnt == CNT_MAX);
    assign w_phase_next = r_phase ^ w_wrap;
    assign w_rise       = {bus.temp_delta, bus.temp_delta_frac};

    always_comb begin
        w_fsm_next = r_fsm;
        w_sil_next = r_sil;
        case (r_fsm)
            RUN_NORMAL, RUN_BORDER, RUN_ATTN: begin
                w_sil_next = '0;
                case (bus.state)
                    4'd0:    w_fsm_next = RUN_NORMAL;
                    4'd1:    w_fsm_next = RUN_BORDER;
                    4'd2:    w_fsm_next = RUN_ATTN;
                    default: w_fsm_next = ALARM_SOUND;
                endcase
            end
            ALARM_SOUND: begin
                if (bus.ack) begin
                    w_fsm_next = ALARM_SILENT;
                    w_sil_next = '0;
                end
            end
            ALARM_SILENT: begin
                // An acknowledge restarts the mute even on a wrap cycle.
                if (bus.ack) begin
                    w_sil_next = '0;
                end else if (w_wrap) begin
                    if (r_sil + SIL_W'(1) == SIL_TOP) begin
                        w_fsm_next = ALARM_SOUND;
                        w_sil_next = '0;
                    end else begin
                        w_sil_next = r_sil + SIL_W'(1);
                    end
                end
            end
            default: begin
                w_fsm_next = RUN_NORMAL;
                w_sil_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they track the
    // inputs sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm             <= RUN_NORMAL;
            r_cnt             <= '0;
            r_phase           <= 1'b0;
            r_sil             <= '0;
            bus.peak_rise     <= '0;
            bus.led_normal    <= 1'b1;
            bus.led_border    <= 1'b0;
            bus.led_attn      <= 1'b0;
            bus.led_emerg     <= 1'b0;
            bus.buzzer        <= 1'b0;
            bus.alarm_latched <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_cnt   <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_phase <= w_phase_next;
            r_sil   <= w_sil_next;
            if (!bus.temp_delta_sign && (w_rise > bus.peak_rise)) begin
                bus.peak_rise <= w_rise;
            end
            bus.led_normal    <= (w_fsm_next == RUN_NORMAL);
            bus.led_border    <= (w_fsm_next == RUN_BORDER);
            bus.led_attn      <= (w_fsm_next == RUN_ATTN) & w_phase_next;
            bus.led_emerg     <= (w_fsm_next == ALARM_SOUND) ||
                                 (w_fsm_next == ALARM_SILENT);
            bus.buzzer        <= (w_fsm_next == ALARM_SOUND) & w_phase_next;
            bus.alarm_latched <= bus.alarm_latched | (w_fsm_next == ALARM_SOUND);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_controller
// Brief   : Directed vector bench for alarm_controller (BLINK_DIV=4, SILENCE_TICKS=2).
// Rev     : 1.0
// ============================================================================
module tb_alarm_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alarm_if bus ();

    alarm_controller #(
        .BLINK_DIV     (4),
        .SILENCE_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] st;
        logic       sg;
        logic [9:0] dl;
        logic       ak;
        logic [3:0] led;   // {emerg, attn, border, normal}
        logic       bz;
        logic       lt;
        logic [9:0] pk;
    } vec_t;

    vec_t vecs [38];

    function automatic vec_t mk(input logic r, input logic [3:0] st, input logic sg,
                                input logic [9:0] dl, input logic ak, input logic [3:0] led,
                                input logic bz, input logic lt, input logic [9:0] pk);
        vec_t v;
        v.r = r; v.st = st; v.sg = sg; v.dl = dl; v.ak = ak;
        v.led = led; v.bz = bz; v.lt = lt; v.pk = pk;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [3:0] st, input logic sg,
                         input logic [9:0] dl, input logic ak);
        rst                 = r;
        bus.state           = st;
        bus.temp_delta_sign = sg;
        bus.temp_delta      = dl[9:4];
        bus.temp_delta_frac = dl[3:0];
        bus.ack             = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] led, input logic bz,
                         input logic lt, input logic [9:0] pk);
        logic [3:0] got_led;
        got_led = {bus.led_emerg, bus.led_attn, bus.led_border, bus.led_normal};
        n_cmp++;
        if ({got_led, bus.buzzer, bus.alarm_latched, bus.peak_rise} !== {led, bz, lt, pk}) begin
            n_bad++;
            $display("FAIL %s: got led=%b buz=%b lat=%b peak=%h, want led=%b buz=%b lat=%b peak=%h",
                     nm, got_led, bus.buzzer, bus.alarm_latched, bus.peak_rise, led, bz, lt, pk);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.state = 4'd0; bus.temp_delta_sign = 1'b1; bus.temp_delta = 6'd0;
        bus.temp_delta_frac = 4'd0; bus.ack = 1'b0;

        //               rst st sg  rise   ack  leds    bz lt peak
        vecs[0]  = mk(1, 0, 1, 10'h000, 0, 4'b0001, 0, 0, 10'h000);
        vecs[1]  = mk(0, 0, 0, 10'h025, 0, 4'b0001, 0, 0, 10'h025);
        vecs[2]  = mk(0, 1, 0, 10'h0A3, 0, 4'b0010, 0, 0, 10'h0A3);
        vecs[3]  = mk(0, 1, 0, 10'h050, 0, 4'b0010, 0, 0, 10'h0A3);
        vecs[4]  = mk(0, 2, 1, 10'h3F0, 0, 4'b0100, 0, 0, 10'h0A3);
        vecs[5]  = mk(0, 2, 1, 10'h000, 1, 4'b0100, 0, 0, 10'h0A3);
        vecs[6]  = mk(0, 2, 1, 10'h000, 0, 4'b0100, 0, 0, 10'h0A3);
        vecs[7]  = mk(0, 2, 1, 10'h000, 0, 4'b0100, 0, 0, 10'h0A3);
        vecs[8]  = mk(0, 2, 1, 10'h000, 0, 4'b0000, 0, 0, 10'h0A3);
        vecs[9]  = mk(0, 0, 1, 10'h000, 0, 4'b0001, 0, 0, 10'h0A3);
        vecs[10] = mk(0, 4, 1, 10'h000, 1, 4'b1000, 0, 1, 10'h0A3);
        vecs[11] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0A3);
        vecs[12] = mk(0, 0, 0, 10'h0B0, 0, 4'b1000, 1, 1, 10'h0B0);
        vecs[13] = mk(0, 0, 0, 10'h0AF, 0, 4'b1000, 1, 1, 10'h0B0);
        vecs[14] = mk(0, 0, 1, 10'h000, 1, 4'b1000, 0, 1, 10'h0B0);
        vecs[15] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[16] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[17] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[18] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[19] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[20] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 1, 1, 10'h0B0);
        vecs[21] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 1, 1, 10'h0B0);
        vecs[22] = mk(0, 0, 1, 10'h000, 1, 4'b1000, 0, 1, 10'h0B0);
        vecs[23] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[24] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[25] = mk(0, 0, 1, 10'h000, 1, 4'b1000, 0, 1, 10'h0B0);
        vecs[26] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[27] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[28] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[29] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[30] = mk(0, 0, 1, 10'h3FF, 0, 4'b1000, 0, 1, 10'h0B0);
        vecs[31] = mk(0, 0, 0, 10'h100, 0, 4'b1000, 0, 1, 10'h100);
        vecs[32] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h100);
        vecs[33] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h100);
        vecs[34] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h100);
        vecs[35] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 0, 1, 10'h100);
        vecs[36] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 1, 1, 10'h100);
        vecs[37] = mk(0, 0, 1, 10'h000, 0, 4'b1000, 1, 1, 10'h100);

        for (int i = 0; i < 38; i++) begin
            drive(vecs[i].r, vecs[i].st, vecs[i].sg, vecs[i].dl, vecs[i].ak);
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].bz, vecs[i].lt, vecs[i].pk);
        end

        // Mute again, then reset mid-silence with emergency code held.
        drive(0, 0, 1, 10'h000, 1);
        check("ack_to_silent", 4'b1000, 1'b0, 1'b1, 10'h100);
        drive(1, 3, 1, 10'h000, 1);
        check("rst_in_silent", 4'b0001, 1'b0, 1'b0, 10'h000);

        // Blink counter restarted at reset: buzzer phase follows edge count.
        for (int k = 1; k <= 12; k++) begin
            drive(0, (k == 1) ? 4'd3 : 4'd0, 1, 10'h000, 0);
            check($sformatf("realarm_k%0d", k), 4'b1000, logic'((k / 4) % 2), 1'b1, 10'h000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period.
REQ-002 Parameter SILENCE_TICKS, default 8: blink half-periods the buzzer stays muted after an acknowledge.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 state  input  4  monitor zone code: 0 normal, 1 borderline, 2 attention, 3 emergency; 4..15 SHALL be treated as emergency.
REQ-006 temp_delta_sign  input  1  0 = rise, 1 = fall or no change.
REQ-007 temp_delta  input  6  integer part of the temperature change magnitude.
REQ-008 temp_delta_frac  input  4  fractional part of the change magnitude, 1/16 units.
REQ-009 ack  input  1  operator acknowledge, single-cycle pulse.
REQ-010 led_normal, led_border, led_attn, led_emerg  output  1 each  zone indicators.
REQ-011 buzzer  output  1  audible alarm drive.
REQ-012 alarm_latched  output  1  sticky flag; emergency seen since reset.
REQ-013 peak_rise  output  10  largest rise seen, {int[5:0], frac[3:0]}.

Function
REQ-014 All outputs SHALL be registered; each output reflects the inputs sampled on the previous clk edge (1-cycle latency).
REQ-015 The blink counter SHALL count 0..BLINK_DIV-1 and wrap; blink_phase SHALL toggle on every wrap; the counter runs free in all FSM states.
REQ-016 The FSM SHALL have states RUN_NORMAL, RUN_BORDER, RUN_ATTN, ALARM_SOUND, ALARM_SILENT.
REQ-017 In the RUN_* states the next state SHALL follow the state input: 0 -> RUN_NORMAL, 1 -> RUN_BORDER, 2 -> RUN_ATTN, >=3 -> ALARM_SOUND.
REQ-018 ALARM_SOUND and ALARM_SILENT SHALL be exited only by rst, regardless of the state input.
REQ-019 ALARM_SOUND + ack -> ALARM_SILENT; the silence counter SHALL load 0.
REQ-020 In ALARM_SILENT the silence counter SHALL increment on each blink wrap; on reaching SILENCE_TICKS -> ALARM_SOUND.
REQ-021 ack in ALARM_SILENT SHALL reload the silence counter to 0 (extends the mute).
REQ-022 ack in any RUN_* state SHALL be ignored.
REQ-023 ack in the same cycle the FSM enters ALARM_SOUND SHALL be ignored.
REQ-024 RUN_NORMAL: led_normal=1. RUN_BORDER: led_border=1. RUN_ATTN: led_attn=blink_phase. ALARM_*: led_emerg=1. All other LEDs SHALL be 0.
REQ-025 buzzer SHALL equal blink_phase in ALARM_SOUND and SHALL be 0 in all other states.
REQ-026 alarm_latched SHALL be set on entry to ALARM_SOUND and held until rst.
REQ-027 When temp_delta_sign=0 and {temp_delta,temp_delta_frac} > peak_rise, peak_rise SHALL load the new value; compare unsigned, 10-bit, no saturation needed.
REQ-028 peak_rise SHALL update in every FSM state, including the alarm states.

Reset
REQ-029 rst SHALL force FSM=RUN_NORMAL, blink counter=0, blink_phase=0, silence counter=0 and peak_rise=0.
REQ-030 After rst: led_normal=1; all other LEDs, buzzer and alarm_latched SHALL be 0.
REQ-031 rst asserted mid-alarm or mid-silence SHALL take effect on the next edge and override ack and the state input.
REQ-032 After rst is released, the first edge SHALL sample the inputs normally.

Verification (BLINK_DIV=4, SILENCE_TICKS=2)
REQ-033 rst, then state=0,1,2 for 20 cycles each -> led_normal, then led_border steady; led_attn toggles every 4 cycles; buzzer=0 throughout.
REQ-034 state=3 for one cycle, then state=0 -> led_emerg=1, alarm_latched=1, buzzer toggles every 4 cycles, and the block stays in alarm.
REQ-035 In ALARM_SOUND, pulse ack -> buzzer=0 for 2 blink wraps (8 cycles), then resumes toggling; a second ack at wrap 1 extends the mute to 2 wraps from that ack.
REQ-036 Rises 0x025, 0x0A3, 0x050 with sign=0, then 0x3F0 with sign=1 -> peak_rise = 0x0A3.
REQ-037 ack and state=3 in the same cycle -> ALARM_SOUND is entered and buzzer starts at the next blink wrap (ack ignored).
REQ-038 rst while in ALARM_SILENT with state=3 held -> next cycle all reset values; the cycle after that, the FSM re-enters ALARM_SOUND.
